// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame length and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  // Data bits + parity + stop, each launched on a device falling edge.
  localparam int PS2_TX_BITS = 10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchroniser for the PS/2 clock and data pads, with a single-cycle clock fall pulse.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_level,
  output logic data_level,
  output logic clk_fall
);

  logic [2:0] clk_sync;
  logic [2:0] data_sync;

  // Reset to the idle-high bus level so leaving reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_i};
      data_sync <= {data_sync[1:0], ps2_data_i};
    end
  end

  assign clk_level  = clk_sync[1];
  assign data_level = data_sync[1];
  assign clk_fall   = clk_sync[2] & ~clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out 10 bits, check ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W  = $clog2(PS2_TX_BITS + 1);

  ps2_state_t       state, state_nx;
  logic [PH_W-1:0]  ph_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [8:0]       frame;
  logic             data_low;
  logic             ack_bad;

  logic clk_level, data_level, clk_fall;
  logic accept, tmo_hit, frame_active, last_bit;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_level  (clk_level),
    .data_level (data_level),
    .clk_fall   (clk_fall)
  );

  assign accept       = (state == IDLE) && tx_valid;
  assign frame_active = (state == DATA) || (state == ACK) || (state == WAIT_IDLE);
  assign tmo_hit      = frame_active && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
  assign last_bit     = (bit_idx == IDX_W'(PS2_TX_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ph_cnt   <= '0;
      tmo_cnt  <= '0;
      bit_idx  <= '0;
      frame    <= '0;
      data_low <= 1'b0;
      ack_bad  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            frame   <= {odd_parity(tx_data), tx_data};
            ph_cnt  <= '0;
            ack_bad <= 1'b0;
          end
        end
        INHIBIT: ph_cnt <= (state_nx == START) ? '0 : ph_cnt + 1'b1;
        START: begin
          if (state_nx == DATA) begin
            ph_cnt   <= '0;
            tmo_cnt  <= '0;
            bit_idx  <= '0;
            data_low <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        DATA: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // Frame shifts out LSB first; the final fall releases the line as the stop bit.
          if (clk_fall && !tmo_hit) begin
            bit_idx  <= bit_idx + 1'b1;
            data_low <= last_bit ? 1'b0 : ~frame[0];
            frame    <= frame >> 1;
          end
        end
        ACK: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (clk_fall && !tmo_hit) ack_bad <= data_level;
        end
        WAIT_IDLE: tmo_cnt <= tmo_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (accept) state_nx = INHIBIT;
      INHIBIT:   if (ph_cnt == PH_W'(INHIBIT_CYCLES - 1)) state_nx = START;
      START:     if (ph_cnt == PH_W'(SETUP_CYCLES - 1)) state_nx = DATA;
      DATA: begin
        if (tmo_hit) state_nx = IDLE;
        else if (clk_fall && last_bit) state_nx = ACK;
      end
      ACK: begin
        if (tmo_hit) state_nx = IDLE;
        else if (clk_fall) state_nx = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (tmo_hit) state_nx = IDLE;
        else if (clk_level && data_level) state_nx = IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_ready           = (state == IDLE);
    busy               = (state != IDLE);
    ps2_clk_drive_low  = (state == INHIBIT) || (state == START);
    ps2_data_drive_low = (state == START) || ((state == DATA) && data_low && !tmo_hit);
    done               = !rst && (state == WAIT_IDLE) && !tmo_hit && clk_level && data_level;
    ack_err            = done && ack_bad;
    timeout            = !rst && tmo_hit;
  end

endmodule
